// File: rtl/jt7759_dfetch_if.sv
// Sample-data bus of the uPD7759 fetch FIFO: ROM port, host write port and control read port.
// master: the fetch block; slave: the ROM/host/control side driving it.
interface jt7759_dfetch_if #(
    parameter int unsigned AW = 17
);
    logic          rd;
    logic [7:0]    dout;
    logic          dout_ok;
    logic          rom_cs;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data;
    logic          rom_ok;
    logic          cs;
    logic          wrn;
    logic [7:0]    din;
    logic          drqn;

    modport master (
        input  rd, rom_data, rom_ok, cs, wrn, din,
        output dout, dout_ok, rom_cs, rom_addr, drqn
    );

    modport slave (
        output rd, rom_data, rom_ok, cs, wrn, din,
        input  dout, dout_ok, rom_cs, rom_addr, drqn
    );
endinterface

// File: rtl/jt7759_dfetch.sv
// Sample-data fetch FIFO for the uPD7759: ROM prefetch (master) or host DRQ writes (slave).
// Optional sticky overflow flag enabled by defining JT7759_DFETCH_OVF_EN.
module jt7759_dfetch #(
    parameter int unsigned AW      = 17,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned DRQ_GAP = 31
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     cen_ctl,
    input  logic                     mdn,
    input  logic                     flush,
    input  logic [AW-1:0]            flush_addr,
    input  logic                     busyn,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    jt7759_dfetch_if.master          bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned GW = (DRQ_GAP > 0) ? $clog2(DRQ_GAP + 1) : 1;

    typedef enum logic { IDLE = 1'b0, REQ = 1'b1 } state_t;

    state_t        state, state_nx;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [GW-1:0] gap;
    logic          rd_l, wr_l, pend;
    logic          clr_c, full_c, empty_c, wr_act_c, wr_edge_c, rd_rise_c;
    logic          push_c, pop_c, store_c;

    assign full_c    = level == CW'(DEPTH);
    assign empty_c   = level == '0;
    assign clr_c     = flush | busyn;
    assign wr_act_c  = bus.cs & ~bus.wrn;
    assign wr_edge_c = wr_act_c & ~wr_l;
    assign rd_rise_c = bus.rd & ~rd_l;
    // a push into a full FIFO only lands if a pop frees the slot on the same edge
    assign store_c   = push_c & (~full_c | pop_c);

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    // Fetch FSM plus push/pop decode; flush and idle force everything back to IDLE
    always_comb begin
        state_nx = state;
        push_c   = 1'b0;
        pop_c    = 1'b0;
        if (clr_c) begin
            state_nx = IDLE;
        end else begin
            pop_c  = bus.rd & (pend | rd_rise_c) & ~empty_c;
            push_c = mdn ? (state == REQ && bus.rom_ok) : wr_edge_c;
            case (state)
                IDLE:    if (!full_c && gap == '0 && !push_c) state_nx = REQ;
                REQ:     if (push_c) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && store_c) mem[wr_ptr] <= mdn ? bus.rom_data : bus.din;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            gap          <= '0;
            pend         <= 1'b0;
            rd_l         <= 1'b0;
            wr_l         <= 1'b0;
            bus.dout     <= 8'd0;
            bus.dout_ok  <= 1'b0;
            bus.rom_addr <= '0;
            bus.rom_cs   <= 1'b0;
            bus.drqn     <= 1'b1;
        end else begin
            rd_l       <= bus.rd;
            wr_l       <= wr_act_c;
            bus.rom_cs <= (state_nx == REQ) & mdn;
            bus.drqn   <= state_nx != REQ;

            if (flush)              bus.rom_addr <= flush_addr;
            else if (push_c && mdn) bus.rom_addr <= bus.rom_addr + AW'(1);

            if (clr_c) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
                pend   <= 1'b0;
            end else begin
                if (store_c) wr_ptr <= wr_ptr + PW'(1);
                if (pop_c)   rd_ptr <= rd_ptr + PW'(1);
                if (store_c && !pop_c)      level <= level + CW'(1);
                else if (pop_c && !store_c) level <= level - CW'(1);
                if (!bus.rd || pop_c) pend <= 1'b0;
                else if (rd_rise_c)   pend <= 1'b1;
            end

            if (pop_c) bus.dout <= mem[rd_ptr];
            if (!bus.rd)    bus.dout_ok <= 1'b0;
            else if (pop_c) bus.dout_ok <= 1'b1;

            // pacing: reload on every push, count down on control clock enables
            if (push_c)                     gap <= GW'(DRQ_GAP);
            else if (cen_ctl && gap != '0)  gap <= gap - GW'(1);
        end
    end

`ifdef JT7759_DFETCH_OVF_EN
    always_ff @(posedge clk) begin
        if (!rstn || flush)                          ovf <= 1'b0;
        else if (push_c && !mdn && full_c && !pop_c) ovf <= 1'b1;
    end
`else
    assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_jt7759_dfetch.sv
// Self-checking bench for jt7759_dfetch: scoreboard of expected FIFO bytes checked on each rd pulse.
module tb_jt7759_dfetch;
    logic        clk = 1'b0;
    logic        rstn;
    logic        cen_ctl = 1'b1;
    logic        cen_div = 1'b0;
    logic        mdn;
    logic        flush;
    logic [16:0] flush_addr;
    logic        busyn;
    logic [2:0]  level;
    logic        ovf;

    int errors = 0;
    int checks = 0;
    int model_cnt = 0;
    logic [7:0] exp_q[$];

    jt7759_dfetch_if #(.AW(17)) bus ();

    jt7759_dfetch #(.AW(17), .DEPTH(4), .DRQ_GAP(3)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cen_ctl    (cen_ctl),
        .mdn        (mdn),
        .flush      (flush),
        .flush_addr (flush_addr),
        .busyn      (busyn),
        .level      (level),
        .ovf        (ovf),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) cen_ctl = cen_div ? ~cen_ctl : 1'b1;

    function automatic logic [7:0] rom_byte(input logic [16:0] a);
        return a[7:0] + 8'h11 + {a[16], 7'd0};
    endfunction

    assign bus.rom_data = rom_byte(bus.rom_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic rd_pulse(input string tag);
        int n = 0;
        logic [7:0] e;
        bus.rd = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.dout_ok && n < 20);
        check({tag, "_ok"}, 32'(bus.dout_ok), 32'd1);
        if (bus.dout_ok && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            model_cnt--;
            check({tag, "_data"}, 32'(bus.dout), 32'(e));
            check({tag, "_level"}, 32'(level), 32'(model_cnt));
        end
        bus.rd = 1'b0;
        @(negedge clk);
        check({tag, "_okclr"}, 32'(bus.dout_ok), 32'd0);
    endtask

    task automatic slave_write(input logic [7:0] d);
        bus.din = d;
        bus.cs  = 1'b1;
        bus.wrn = 1'b0;
        @(negedge clk);
        bus.cs  = 1'b0;
        bus.wrn = 1'b1;
        if (model_cnt < 4) begin
            exp_q.push_back(d);
            model_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic wait_drq(input string tag);
        int n = 0;
        while (bus.drqn !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(bus.drqn), 32'd0);
    endtask

    initial begin
        int n;
        logic exp_ovf;
`ifdef JT7759_DFETCH_OVF_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        rstn = 1'b0; mdn = 1'b1; flush = 1'b0; flush_addr = '0; busyn = 1'b1;
        bus.rd = 1'b0; bus.rom_ok = 1'b0; bus.cs = 1'b0; bus.wrn = 1'b1; bus.din = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_drqn", 32'(bus.drqn), 32'd1);
        check("rst_romcs", 32'(bus.rom_cs), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_dout_ok", 32'(bus.dout_ok), 32'd0);
        check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rstn = 1'b1;

        // master prefetch across the address wrap
        flush = 1'b1; flush_addr = 17'h1FFFF; busyn = 1'b0; bus.rom_ok = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(rom_byte(17'h1FFFF + 17'(i)));
        model_cnt = 4;
        n = 0;
        while (level != 3'd4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        bus.rom_ok = 1'b0;
        check("fill_level", 32'(level), 32'd4);
        check("fill_drqn", 32'(bus.drqn), 32'd1);
        check("fill_romcs", 32'(bus.rom_cs), 32'd0);
        check("fill_addr_wrap", 32'(bus.rom_addr), 32'd3);
        for (int i = 0; i < 4; i++) rd_pulse($sformatf("mrd%0d", i));
        wait_drq("drain_drqn");
        check("drain_romcs", 32'(bus.rom_cs), 32'd1);

        // pacing: one push, then gap of 3 ticks at half rate
        cen_div = 1'b1;
        @(negedge clk);
        bus.rom_ok = 1'b1;
        exp_q.push_back(rom_byte(17'd3));
        model_cnt = 1;
        @(negedge clk);
        bus.rom_ok = 1'b0;
        check("gap_level", 32'(level), 32'd1);
        check("gap_addr", 32'(bus.rom_addr), 32'd4);
        check("gap_drqn_hi", 32'(bus.drqn), 32'd1);
        n = 0;
        while (bus.drqn !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("gap_min", 32'(n >= 6), 32'd1);
        check("gap_max", 32'(n <= 8), 32'd1);
        cen_div = 1'b0;
        rd_pulse("grd");

        // slave mode: five writes into four slots
        busyn = 1'b1; mdn = 1'b0;
        @(negedge clk);
        busyn = 1'b0;
        wait_drq("slv_drqn");
        check("slv_romcs", 32'(bus.rom_cs), 32'd0);
        for (int i = 0; i < 5; i++) slave_write(8'h30 + 8'(i));
        check("slv_level", 32'(level), 32'd4);
        check("slv_ovf", 32'(ovf), 32'(exp_ovf));
        for (int i = 0; i < 2; i++) rd_pulse($sformatf("srd%0d", i));
        flush = 1'b1; flush_addr = 17'h00123;
        @(negedge clk);
        flush = 1'b0;
        exp_q.delete();
        model_cnt = 0;
        check("flush_ovf", 32'(ovf), 32'd0);
        check("flush_level", 32'(level), 32'd0);
        check("flush_addr", 32'(bus.rom_addr), 32'h00123);

        // master flush in mid request, with rom_ok on the same edge
        busyn = 1'b1; mdn = 1'b1;
        @(negedge clk);
        busyn = 1'b0;
        wait_drq("mreq_drqn");
        bus.rom_ok = 1'b1; flush = 1'b1; flush_addr = 17'h0ABCD;
        @(negedge clk);
        bus.rom_ok = 1'b0; flush = 1'b0;
        check("mflush_level", 32'(level), 32'd0);
        check("mflush_addr", 32'(bus.rom_addr), 32'h0ABCD);
        check("mflush_drqn", 32'(bus.drqn), 32'd1);
        check("mflush_romcs", 32'(bus.rom_cs), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
